// File: rtl/serial_adder_ctrl_pkg.sv
// Types and constants for serial_adder_ctrl, built on the shared defs include.
package serial_adder_ctrl_pkg;
`include "serial_adder_defs.vh"

  typedef enum logic [1:0] {
    S_IDLE = `SA_IDLE,
    S_ADD  = `SA_ADD,
    S_DONE = `SA_DONE
  } state_t;

  localparam int DIGIT = `SA_DIGIT;
endpackage

// File: rtl/adder_2bit_cin.sv
// Two-bit ripple adder with carry-in; the datapath slice of the serial adder.
module adder_2bit_cin (
  output logic       Carry,
  output logic [1:0] Sum,
  input  logic [1:0] A,
  input  logic [1:0] B,
  input  logic       Cin
);
  logic c0;

  full_adder u_fa0 (.a(A[0]), .b(B[0]), .cin(Cin), .sum(Sum[0]), .cout(c0));
  full_adder u_fa1 (.a(A[1]), .b(B[1]), .cin(c0),  .sum(Sum[1]), .cout(Carry));
endmodule

// File: rtl/full_adder.sv
// One-bit full adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder_defs.vh
// Shared encodings for the digit-serial adder: FSM state codes and digit width.
`ifndef SERIAL_ADDER_DEFS_VH
`define SERIAL_ADDER_DEFS_VH
`define SA_IDLE  2'b00
`define SA_ADD   2'b01
`define SA_DONE  2'b10
`define SA_DIGIT 2
`endif

// File: rtl/serial_adder_ctrl.sv
// Digit-serial WIDTH-bit adder: two bits per cycle, LSB digit first, Done pulse on completion.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVERFLOW_EN.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry
`ifdef SERIAL_ADDER_OVERFLOW_EN
  ,
  output logic             Overflow
`endif
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG + 1);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_t           state;
  logic [WIDTH-1:0] op_a, op_b;
  logic [CW-1:0]    cnt;
  logic             cy;
  logic [DIGIT-1:0] s_sum;
  logic             s_cy;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic [1:0]       msb;
`endif

  adder_2bit_cin u_slice (
    .Carry (s_cy),
    .Sum   (s_sum),
    .A     (op_a[DIGIT-1:0]),
    .B     (op_b[DIGIT-1:0]),
    .Cin   (cy)
  );

  assign Carry = cy;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= S_IDLE;
      op_a  <= '0;
      op_b  <= '0;
      Sum   <= '0;
      cy    <= 1'b0;
      cnt   <= '0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      msb      <= 2'b00;
      Overflow <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            op_a  <= A;
            op_b  <= B;
            cy    <= 1'b0;
            cnt   <= '0;
            Busy  <= 1'b1;
            state <= S_ADD;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            msb <= {A[WIDTH-1], B[WIDTH-1]};
`endif
          end
        end
        S_ADD: begin
          op_a <= op_a >> DIGIT;
          op_b <= op_b >> DIGIT;
          Sum  <= {s_sum, Sum[WIDTH-1:DIGIT]};
          cy   <= s_cy;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            Busy  <= 1'b0;
            Done  <= 1'b1;
            state <= S_DONE;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            // s_sum[1] is the final result MSB landing on this edge
            Overflow <= (msb[1] == msb[0]) && (s_sum[DIGIT-1] != msb[1]);
`endif
          end
        end
        S_DONE: begin
          Done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8) with a cycle-level result model.
module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic         Clk = 1'b0, Reset = 1'b1, Start = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic         Busy, Done, Carry;
  logic [W-1:0] Sum;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic         Overflow;
`endif

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .Sum(Sum), .Carry(Carry)
`ifdef SERIAL_ADDER_OVERFLOW_EN
    , .Overflow(Overflow)
`endif
  );

  always #5 Clk = ~Clk;

  int checks = 0, errors = 0, cyc = 0, done_cnt = 0, last_done = 0, gap = 0;
  int phase = 0;
  logic [W:0] pend = '0, e_res = '0;
  logic       pend_ov = 1'b0, e_ov = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: phase 0 idle, 1..W/2 adding, W/2+1 done; result is plain A+B.
  always @(posedge Clk) begin
    cyc++;
    if (Reset) begin
      phase = 0; e_res = '0; e_ov = 1'b0;
    end else if (phase == 0) begin
      if (Start) begin
        phase   = 1;
        pend    = {1'b0, A} + {1'b0, B};
        pend_ov = (A[W-1] == B[W-1]) && (pend[W-1] != A[W-1]);
      end
    end else if (phase < W/2) begin
      phase++;
    end else if (phase == W/2) begin
      phase++; e_res = pend; e_ov = pend_ov;
    end else begin
      phase = 0;
    end
    #1;
    chk("busy", Busy, (phase >= 1 && phase <= W/2));
    chk("done", Done, (phase == W/2 + 1));
    if (Done) begin
      done_cnt++; gap = cyc - last_done; last_done = cyc;
    end
    if (phase == 0 || phase == W/2 + 1) begin
      chk("sum", Sum, e_res[W-1:0]);
      chk("carry", Carry, e_res[W]);
`ifdef SERIAL_ADDER_OVERFLOW_EN
      chk("overflow", Overflow, e_ov);
`endif
    end
  end

  // Called at a negedge in IDLE; returns edges to Done and Busy cycle count, ends in IDLE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int bc);
    Start = 1'b1; A = a; B = b;
    bc = 0;
    for (lat = 1; lat <= 20; lat++) begin
      @(negedge Clk);
      Start = 1'b0;
      if (Busy) bc++;
      if (Done) break;
    end
    @(negedge Clk);
  endtask

  int lat, bc, d0, n;

  initial begin
    repeat (2) @(negedge Clk);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_sum", Sum, 0);
    chk("rst_carry", Carry, 0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
    chk("rst_ovf", Overflow, 0);
`endif
    Reset = 1'b0;
    @(negedge Clk);

    // Basic add
    run_op(8'h5A, 8'h3C, lat, bc);
    chk("basic_lat", lat, 5);
    chk("basic_sum", Sum, 8'h96);
    chk("basic_carry", Carry, 0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
    chk("basic_ovf", Overflow, 1);
`endif

    // Full carry ripple
    run_op(8'hFF, 8'h01, lat, bc);
    chk("ripple_lat", lat, 5);
    chk("ripple_busy", bc, 4);
    chk("ripple_sum", Sum, 8'h00);
    chk("ripple_carry", Carry, 1);
`ifdef SERIAL_ADDER_OVERFLOW_EN
    chk("ripple_ovf", Overflow, 0);
`endif

    // Start ignored in ADD and DONE
    d0 = done_cnt;
    Start = 1'b1; A = 8'h10; B = 8'h20;
    @(negedge Clk); Start = 1'b0; A = 8'hFF; B = 8'hFF;
    @(negedge Clk); Start = 1'b1;
    @(negedge Clk); Start = 1'b0;
    @(negedge Clk);
    @(negedge Clk); chk("ign_done_now", Done, 1); Start = 1'b1;
    @(negedge Clk); Start = 1'b0;
    repeat (4) @(negedge Clk);
    chk("ign_pulses", done_cnt - d0, 1);
    chk("ign_sum", Sum, 8'h30);
    chk("ign_carry", Carry, 0);

    // Reset mid-operation
    d0 = done_cnt;
    Start = 1'b1; A = 8'hAA; B = 8'h55;
    @(negedge Clk); Start = 1'b0;
    @(negedge Clk); Reset = 1'b1;
    @(negedge Clk); Reset = 1'b0;
    chk("mid_busy", Busy, 0);
    chk("mid_done", Done, 0);
    chk("mid_sum", Sum, 0);
    chk("mid_carry", Carry, 0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
    chk("mid_ovf", Overflow, 0);
`endif
    repeat (6) @(negedge Clk);
    chk("mid_nodone", done_cnt - d0, 0);
    run_op(8'h01, 8'h01, lat, bc);
    chk("mid_follow_sum", Sum, 8'h02);
    chk("mid_follow_carry", Carry, 0);

    // Back-to-back with Start held high
    n = 0;
    Start = 1'b1; A = 8'h80; B = 8'h80;
    for (int i = 0; i < 24; i++) begin
      @(negedge Clk);
      if (Done) begin
        n++;
        if (n > 1) chk("b2b_gap", gap, 6);
        chk("b2b_sum", Sum, 8'h00);
        chk("b2b_carry", Carry, 1);
`ifdef SERIAL_ADDER_OVERFLOW_EN
        chk("b2b_ovf", Overflow, 1);
`endif
      end
    end
    Start = 1'b0;
    chk("b2b_count", n, 4);
    repeat (8) @(negedge Clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
